// File: rtl/m_seq_sync_ctrl.sv
// Receive-side alignment controller for the 3-bit m-sequence (s[2]^s[0] recurrence):
// searches the serial stream, verifies predictions, then flywheels a local copy to hold lock.
module m_seq_sync_ctrl #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             rx_bit,
  input  logic             resync,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic             frame_start,
  output logic [2:0]       lfsr_q,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FILL_W = 2;
  localparam int unsigned SR_W   = 3;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t             state;
  logic [SR_W-1:0]    sr;
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   match_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  logic               pred;
  logic [SR_W-1:0]    sr_rx;
  logic [SR_W-1:0]    sr_pred;
  logic [FILL_W-1:0]  fill_inc;
  logic [CNT_W-1:0]   match_inc;
  logic [CNT_W-1:0]   miss_inc;
  logic [ERR_W-1:0]   err_sat;

  // Next-bit prediction and candidate register/counter updates
  assign pred      = sr[2] ^ sr[0];
  assign sr_rx     = {sr[1:0], rx_bit};
  assign sr_pred   = {sr[1:0], pred};
  assign fill_inc  = (fill == FILL_W'(3)) ? FILL_W'(3) : fill + FILL_W'(1);
  assign match_inc = match_cnt + CNT_W'(1);
  assign miss_inc  = miss_cnt + CNT_W'(1);
  assign err_sat   = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_SEARCH;
      sr          <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else if (resync) begin
      state       <= ST_SEARCH;
      sr          <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else if (bit_valid) begin
      frame_start <= 1'b0;
      case (state)
        ST_SEARCH: begin
          sr   <= sr_rx;
          fill <= fill_inc;
          // All-zero register is the degenerate LFSR state; never verify from it
          if (fill_inc == FILL_W'(3) && sr_rx != '0) begin
            state     <= ST_VERIFY;
            match_cnt <= '0;
          end
        end
        ST_VERIFY: begin
          sr <= sr_rx;
          if (rx_bit == pred) begin
            if (match_inc == CNT_W'(LOCK_CNT)) begin
              state     <= ST_LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_inc;
            end
          end else begin
            match_cnt <= '0;
            if (sr_rx == '0) begin
              state <= ST_SEARCH;
              fill  <= FILL_W'(3);
            end
          end
        end
        ST_LOCKED: begin
          // Flywheel: the local copy advances on prediction, the line only scores it
          sr          <= sr_pred;
          frame_start <= (sr_pred == 3'b101);
          if (rx_bit != pred) begin
            err_cnt <= err_sat;
            if (miss_inc == CNT_W'(MISS_MAX)) begin
              state       <= ST_SEARCH;
              locked      <= 1'b0;
              sr          <= '0;
              fill        <= '0;
              match_cnt   <= '0;
              miss_cnt    <= '0;
              frame_start <= 1'b0;
            end else begin
              miss_cnt <= miss_inc;
            end
          end else begin
            miss_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_SEARCH;
          locked    <= 1'b0;
          sr        <= '0;
          fill      <= '0;
          match_cnt <= '0;
          miss_cnt  <= '0;
        end
      endcase
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign sync_state = state;
  assign lfsr_q     = sr;

endmodule

// File: tb/tb_m_seq_sync_ctrl.sv
// Directed bench for m_seq_sync_ctrl: acquisition, flywheel errors, zero stream,
// verify mismatch, gapped valid, resync priority and async reset.
module tb_m_seq_sync_ctrl;

  localparam int unsigned ERR_W = 8;

  logic             clk;
  logic             rst;
  logic             bit_valid;
  logic             rx_bit;
  logic             resync;
  logic             locked;
  logic [1:0]       sync_state;
  logic             frame_start;
  logic [2:0]       lfsr_q;
  logic [ERR_W-1:0] err_cnt;

  int unsigned total;
  int unsigned passed;

  m_seq_sync_ctrl #(.LOCK_CNT(4), .MISS_MAX(3), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .rx_bit      (rx_bit),
    .resync      (resync),
    .locked      (locked),
    .sync_state  (sync_state),
    .frame_start (frame_start),
    .lfsr_q      (lfsr_q),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    rx_bit    = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic idle(input logic b);
    @(negedge clk);
    bit_valid = 1'b0;
    rx_bit    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_resync(input logic b);
    @(negedge clk);
    resync    = 1'b1;
    bit_valid = 1'b1;
    rx_bit    = b;
    @(posedge clk);
    #1;
    resync    = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [2:0] sr,
                         input logic fs, input logic [ERR_W-1:0] err);
    chk({tag, ".state"}, 32'(sync_state), 32'(st));
    chk({tag, ".locked"}, 32'(locked), 32'(st == 2'b10));
    chk({tag, ".lfsr"}, 32'(lfsr_q), 32'(sr));
    chk({tag, ".fs"}, 32'(frame_start), 32'(fs));
    chk({tag, ".err"}, 32'(err_cnt), 32'(err));
  endtask

  // Hand-derived acquisition trace: bits 1,0,1,0,0,1,1,1,0,1
  logic       acq_bit [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] acq_st  [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
  logic [2:0] acq_sr  [10] = '{3'd1, 3'd2, 3'd5, 3'd2, 3'd4, 3'd1, 3'd3, 3'd7, 3'd6, 3'd5};
  logic       acq_fs  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    bit_valid = 1'b0;
    rx_bit    = 1'b0;
    resync    = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk_all("reset", 2'd0, 3'd0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Lock acquisition
    for (int i = 0; i < 10; i++) begin
      send(acq_bit[i]);
      chk_all($sformatf("acq%0d", i + 1), acq_st[i], acq_sr[i], acq_fs[i], '0);
    end
    send(1'b0);
    chk_all("acq11", 2'd2, 3'd2, 1'b0, '0);

    // Flywheel: single flip, recovery, then three consecutive flips
    send(1'b1);
    chk_all("fly_flip1", 2'd2, 3'd4, 1'b0, 8'd1);
    send(1'b1);
    chk_all("fly_good", 2'd2, 3'd1, 1'b0, 8'd1);
    send(1'b0);
    chk_all("fly_f2a", 2'd2, 3'd3, 1'b0, 8'd2);
    send(1'b0);
    chk_all("fly_f2b", 2'd2, 3'd7, 1'b0, 8'd3);
    send(1'b1);
    chk_all("fly_drop", 2'd0, 3'd0, 1'b0, 8'd4);

    // Zero stream never leaves SEARCH
    for (int i = 0; i < 20; i++) begin
      send(1'b0);
      chk($sformatf("zero%0d.state", i), 32'(sync_state), 32'd0);
      chk($sformatf("zero%0d.lfsr", i), 32'(lfsr_q), 32'd0);
    end
    chk("zero.err_kept", 32'(err_cnt), 32'd4);

    // Resync with a concurrent valid bit: bit discarded, all counters cleared
    do_resync(1'b1);
    chk_all("resync_search", 2'd0, 3'd0, 1'b0, '0);

    // VERIFY mismatch: 3 fill bits, 2 matches, one wrong bit, then 4 matches
    send(1'b0);
    chk_all("vf_fill1", 2'd0, 3'd0, 1'b0, '0);
    send(1'b1);
    chk_all("vf_fill2", 2'd0, 3'd1, 1'b0, '0);
    send(1'b0);
    chk_all("vf_verify", 2'd1, 3'd2, 1'b0, '0);
    send(1'b0);
    chk_all("vf_m1", 2'd1, 3'd4, 1'b0, '0);
    send(1'b1);
    chk_all("vf_m2", 2'd1, 3'd1, 1'b0, '0);
    send(1'b0);
    chk_all("vf_wrong", 2'd1, 3'd2, 1'b0, '0);
    send(1'b0);
    chk_all("vf_r1", 2'd1, 3'd4, 1'b0, '0);
    send(1'b1);
    chk_all("vf_r2", 2'd1, 3'd1, 1'b0, '0);
    send(1'b1);
    chk_all("vf_r3", 2'd1, 3'd3, 1'b0, '0);
    send(1'b1);
    chk_all("vf_lock", 2'd2, 3'd7, 1'b0, '0);

    // Gapped valid while locked: idle cycles hold state, single frame_start pulse
    send(1'b0);
    chk_all("gap_b1", 2'd2, 3'd6, 1'b0, '0);
    idle(1'b0);
    chk_all("gap_idle1", 2'd2, 3'd6, 1'b0, '0);
    send(1'b1);
    chk_all("gap_b2", 2'd2, 3'd5, 1'b1, '0);
    idle(1'b1);
    chk_all("gap_idle2", 2'd2, 3'd5, 1'b0, '0);

    // Resync during lock clears err_cnt and ignores the bit
    send(1'b1);
    chk_all("lk_flip", 2'd2, 3'd2, 1'b0, 8'd1);
    do_resync(1'b1);
    chk_all("lk_resync", 2'd0, 3'd0, 1'b0, '0);

    // Reacquire, take an error, then async reset between edges
    for (int i = 0; i < 7; i++) send(acq_bit[i]);
    chk_all("re_lock", 2'd2, 3'd3, 1'b0, '0);
    send(1'b0);
    chk_all("re_err", 2'd2, 3'd7, 1'b0, 8'd1);
    #3 rst = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 3'd0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) send(acq_bit[i]);
    chk_all("post_rst6", 2'd1, 3'd1, 1'b0, '0);
    send(acq_bit[6]);
    chk_all("post_rst7", 2'd2, 3'd3, 1'b0, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
